// File: rtl/fft_8p_frame_sched.sv
// Frame scheduler for the 8-point FFT datapath.
// Loads 8 samples into the s2p register over a valid/ready handshake, fires the three
// butterfly stages in turn, then drains 8 results over a second valid/ready handshake.
module fft_8p_frame_sched #(
    parameter bit          BITREV_IN = 1'b1,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              s2p_we,
    output logic [2:0]        s2p_addr,
    output logic [3:0]        en_bf1,
    output logic [1:0]        en_bf2,
    output logic              en_bf3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_sel,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        StLoad,
        StBf1,
        StBf2,
        StBf3,
        StDrain
    } state_e;

    state_e            r_state;
    logic [2:0]        r_idx;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_frame_done;

    logic              w_load;
    logic              w_drain;
    logic              w_accept;
    logic              w_out_hs;

    // Handshake qualifiers and outputs decoded from state; reset_n gates the ready/valid
    // pair so nothing is offered while the block is held in reset.
    always_comb begin
        w_load     = (r_state == StLoad);
        w_drain    = (r_state == StDrain);
        in_ready   = reset_n & enable & ~flush & w_load;
        out_valid  = reset_n & ~flush & w_drain;
        w_accept   = in_ready & in_valid;
        w_out_hs   = out_valid & out_ready;
        s2p_we     = w_accept;
        s2p_addr   = 3'd0;
        if (w_load) begin
            s2p_addr = BITREV_IN ? {r_idx[0], r_idx[1], r_idx[2]} : r_idx;
        end
        out_sel    = w_drain ? r_idx : 3'd0;
        en_bf1     = {4{r_state == StBf1}};
        en_bf2     = {2{r_state == StBf2}};
        en_bf3     = (r_state == StBf3);
        frame_done = r_frame_done;
        frame_cnt  = r_frame_cnt;
    end

    // Frame FSM: shared index counter for load and drain, flush returns to an empty load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StLoad;
            r_idx        <= 3'd0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (flush) begin
                r_state <= StLoad;
                r_idx   <= 3'd0;
            end else begin
                case (r_state)
                    StLoad: begin
                        if (w_accept) begin
                            r_idx <= r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                r_state <= StBf1;
                            end
                        end
                    end
                    StBf1: r_state <= StBf2;
                    StBf2: r_state <= StBf3;
                    StBf3: r_state <= StDrain;
                    StDrain: begin
                        if (w_out_hs) begin
                            r_idx <= r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                r_state      <= StLoad;
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= StLoad;
                        r_idx   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_8p_frame_sched.sv
// Directed bench for fft_8p_frame_sched: bit-reversed and natural-order instances
// share all inputs; expected values are hand-derived constants.
module tb_fft_8p_frame_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       flush;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready, s2p_we, en_bf3, out_valid, frame_done;
    logic [2:0] s2p_addr, out_sel;
    logic [3:0] en_bf1;
    logic [1:0] en_bf2;
    logic [7:0] frame_cnt;

    logic       n_in_ready, n_s2p_we, n_en_bf3, n_out_valid, n_frame_done;
    logic [2:0] n_s2p_addr, n_out_sel;
    logic [3:0] n_en_bf1;
    logic [1:0] n_en_bf2;
    logic [7:0] n_frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] br_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    always #5 clk = ~clk;

    fft_8p_frame_sched #(.BITREV_IN(1'b1), .FCNT_W(8)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s2p_we     (s2p_we),
        .s2p_addr   (s2p_addr),
        .en_bf1     (en_bf1),
        .en_bf2     (en_bf2),
        .en_bf3     (en_bf3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    fft_8p_frame_sched #(.BITREV_IN(1'b0), .FCNT_W(8)) u_nat (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (n_in_ready),
        .s2p_we     (n_s2p_we),
        .s2p_addr   (n_s2p_addr),
        .en_bf1     (n_en_bf1),
        .en_bf2     (n_en_bf2),
        .en_bf3     (n_en_bf3),
        .out_valid  (n_out_valid),
        .out_ready  (out_ready),
        .out_sel    (n_out_sel),
        .frame_done (n_frame_done),
        .frame_cnt  (n_frame_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Eight back-to-back input handshakes starting in the current (LOAD, idx 0) cycle.
    task automatic do_load();
        enable    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("load_in_ready", in_ready, 1);
            check("load_s2p_we", s2p_we, 1);
            check("load_addr_bitrev", s2p_addr, br_tab[k]);
            check("load_addr_nat", n_s2p_addr, k);
            check("load_no_out_valid", out_valid, 0);
            nxt();
        end
    endtask

    task automatic do_bf();
        #1;
        check("bf1_en1", en_bf1, 15);
        check("bf1_en2", en_bf2, 0);
        check("bf1_en3", en_bf3, 0);
        check("bf1_in_ready", in_ready, 0);
        check("bf1_out_valid", out_valid, 0);
        nxt();
        #1;
        check("bf2_en1", en_bf1, 0);
        check("bf2_en2", en_bf2, 3);
        check("bf2_en3", en_bf3, 0);
        nxt();
        #1;
        check("bf3_en2", en_bf2, 0);
        check("bf3_en3", en_bf3, 1);
        check("bf3_out_valid", out_valid, 0);
        nxt();
    endtask

    task automatic do_drain();
        for (int k = 0; k < 8; k++) begin
            #1;
            check("drain_out_valid", out_valid, 1);
            check("drain_out_sel", out_sel, k);
            check("drain_in_ready", in_ready, 0);
            check("drain_en3", en_bf3, 0);
            check("drain_no_done", frame_done, 0);
            nxt();
        end
    endtask

    task automatic check_done(input int cnt);
        #1;
        check("done_pulse", frame_done, 1);
        check("done_cnt", frame_cnt, cnt);
        check("done_in_ready", in_ready, 1);
        check("done_nat_cnt", n_frame_cnt, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int hold;

        // Reset state
        reset_n   = 1'b0;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s2p_we", s2p_we, 0);
        check("rst_s2p_addr", s2p_addr, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_en1", en_bf1, 0);
        check("rst_en2", en_bf2, 0);
        check("rst_en3", en_bf3, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        nxt();
        reset_n = 1'b1;

        // Frame 1: continuous streaming, 19-cycle period
        do_load();
        do_bf();
        do_drain();
        check_done(1);

        // Frame 2: input gaps plus enable low after the 4th sample, then output back-pressure
        s    = 0;
        c    = 0;
        hold = 0;
        while (s < 8 && c < 60) begin
            if (hold > 0) begin
                enable   = 1'b0;
                in_valid = 1'b1;
                #1;
                check("gap_en_low_ready", in_ready, 0);
                check("gap_en_low_we", s2p_we, 0);
                check("gap_idx_hold", n_s2p_addr, 4);
                hold--;
            end else begin
                enable   = 1'b1;
                in_valid = (c % 2 == 0);
                #1;
                check("gap_in_ready", in_ready, 1);
                check("gap_we", s2p_we, int'(in_valid));
                check("gap_addr_nat", n_s2p_addr, s);
                check("gap_addr_bitrev", s2p_addr, br_tab[s]);
                if (in_valid) begin
                    s++;
                    if (s == 4) hold = 3;
                end
            end
            c++;
            nxt();
        end
        check("gap_samples", s, 8);
        in_valid = 1'b1;
        do_bf();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_out_sel", out_sel, k);
            nxt();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sel", out_sel, 3);
            nxt();
        end
        out_ready = 1'b1;
        for (int k = 3; k < 8; k++) begin
            #1;
            check("bp_out_sel", out_sel, k);
            check("bp_no_done", frame_done, 0);
            nxt();
        end
        check_done(2);

        // Flush during LOAD at idx 5
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fl_load_addr", n_s2p_addr, k);
            nxt();
        end
        flush = 1'b1;
        #1;
        check("fl_load_ready", in_ready, 0);
        check("fl_load_we", s2p_we, 0);
        nxt();
        flush = 1'b0;
        #1;
        check("fl_load_idx0", n_s2p_addr, 0);
        check("fl_load_no_done", frame_done, 0);
        check("fl_load_cnt", frame_cnt, 2);
        do_load();
        do_bf();
        do_drain();
        check_done(3);

        // Flush during BF2
        do_load();
        #1;
        check("fl_bf_en1", en_bf1, 15);
        nxt();
        flush = 1'b1;
        #1;
        check("fl_bf_out_valid", out_valid, 0);
        nxt();
        flush = 1'b0;
        #1;
        check("fl_bf_en3", en_bf3, 0);
        check("fl_bf_ready", in_ready, 1);
        check("fl_bf_idx0", n_s2p_addr, 0);
        check("fl_bf_no_done", frame_done, 0);
        do_load();
        do_bf();
        do_drain();
        check_done(4);

        // Flush during DRAIN at out_sel 6 with out_ready high
        do_load();
        do_bf();
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fl_dr_sel", out_sel, k);
            nxt();
        end
        flush = 1'b1;
        #1;
        check("fl_dr_out_valid", out_valid, 0);
        check("fl_dr_in_ready", in_ready, 0);
        nxt();
        flush = 1'b0;
        #1;
        check("fl_dr_ready", in_ready, 1);
        check("fl_dr_out_valid_after", out_valid, 0);
        check("fl_dr_no_done", frame_done, 0);
        check("fl_dr_cnt", frame_cnt, 4);
        check("fl_dr_idx0", n_s2p_addr, 0);
        do_load();
        do_bf();
        do_drain();
        check_done(5);

        // Asynchronous reset during BF3
        do_load();
        nxt();
        nxt();
        #1;
        check("rb_en3_before", en_bf3, 1);
        reset_n = 1'b0;
        #1;
        check("rb_en3", en_bf3, 0);
        check("rb_en1", en_bf1, 0);
        check("rb_in_ready", in_ready, 0);
        check("rb_out_valid", out_valid, 0);
        check("rb_s2p_we", s2p_we, 0);
        check("rb_cnt", frame_cnt, 0);
        nxt();
        reset_n = 1'b1;
        #1;
        check("rb_rel_ready", in_ready, 1);
        check("rb_rel_cnt", frame_cnt, 0);
        check("rb_rel_idx0", n_s2p_addr, 0);

        // 256 frames: frame_cnt wraps 255 -> 0
        for (int f = 0; f < 256; f++) begin
            do_load();
            do_bf();
            do_drain();
            check_done((f + 1) % 256);
        end
        check("wrap_cnt", frame_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
